neuron_tdm_controller: RTL and testbench

- Time-division-multiplexed sequencer for the neuron state LUTRAM.
- On each timestep it sweeps all neurons once: reads Vmem/refractory state and the neuron's input current, applies a leaky integrate-and-fire (LIF) update, writes the result back, and emits spike events.
- Also performs a bulk state initialisation.
- Sits between the timestep scheduler, the state LUTRAM (1-cycle registered read, synchronous write) and the spike router.

---
 rtl/neuron_tdm_controller.sv | 179 +++++++++++++++++
 tb/tb_neuron_tdm_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_tdm_controller.sv
// Time-multiplexed LIF sequencer over the neuron state LUTRAM; also bulk-clears state.
// Latency: NUM_NEURONS+1 cycles per sweep; backpressure: a refused spike stalls the pipeline.
module neuron_tdm_controller #(
   parameter int NUM_NEURONS   = 128,
   parameter int VMEM_WIDTH    = 16,
   parameter int REF_CTR_WIDTH = 4,
   parameter int CUR_WIDTH     = 16,
   localparam int ADDR_W       = $clog2(NUM_NEURONS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_step_start,
   input  logic                     i_init_start,
   input  logic [VMEM_WIDTH-1:0]    i_cfg_vth,
   input  logic [VMEM_WIDTH-1:0]    i_cfg_vreset,
   input  logic [3:0]               i_cfg_leak_shift,
   input  logic [REF_CTR_WIDTH-1:0] i_cfg_ref_period,
   output logic [ADDR_W-1:0]        o_rd_addr,
   input  logic [VMEM_WIDTH-1:0]    i_vmem_rd,
   input  logic [REF_CTR_WIDTH-1:0] i_ref_rd,
   input  logic [CUR_WIDTH-1:0]     i_cur_rd,
   output logic                     o_wr_en,
   output logic [ADDR_W-1:0]        o_wr_addr,
   output logic [VMEM_WIDTH-1:0]    o_vmem_wr,
   output logic [REF_CTR_WIDTH-1:0] o_ref_wr,
   output logic                     o_spike_valid,
   output logic [ADDR_W-1:0]        o_spike_addr,
   input  logic                     i_spike_ready,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam int SW = VMEM_WIDTH + 2;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);
   localparam logic signed [SW-1:0] VMAX = {3'b000, {(VMEM_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] VMIN = {3'b111, {(VMEM_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, INIT, SWEEP, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]          s2_addr_q, s2_addr_d;
   logic                       s2_vld_q, s2_vld_d;
   logic                       cfg_load;

   logic signed [VMEM_WIDTH-1:0] vth_q, vreset_q;
   logic [3:0]                   shift_q;
   logic [REF_CTR_WIDTH-1:0]     refp_q;

   logic signed [SW-1:0]         v_ext, c_ext, leak, sum;
   logic signed [VMEM_WIDTH-1:0] sat, upd_vmem;
   logic [REF_CTR_WIDTH-1:0]     upd_ref;
   logic                         fire, s2_act, spike, stall;

   // LIF update on the S2 read data; sum is kept 2 bits wider so it cannot wrap
   always_comb begin
      v_ext = {{2{i_vmem_rd[VMEM_WIDTH-1]}}, i_vmem_rd};
      c_ext = {{(SW-CUR_WIDTH){i_cur_rd[CUR_WIDTH-1]}}, i_cur_rd};
      leak  = (shift_q == 4'd0) ? '0 : (v_ext >>> shift_q);
      sum   = v_ext - leak + c_ext;
      if (sum > VMAX)
         sat = {1'b0, {(VMEM_WIDTH-1){1'b1}}};
      else if (sum < VMIN)
         sat = {1'b1, {(VMEM_WIDTH-1){1'b0}}};
      else
         sat = sum[VMEM_WIDTH-1:0];

      fire     = 1'b0;
      upd_vmem = vreset_q;
      upd_ref  = '0;
      if (i_ref_rd != '0) begin
         upd_ref = i_ref_rd - REF_CTR_WIDTH'(1);
      end else if (sat >= vth_q) begin
         fire    = 1'b1;
         upd_ref = refp_q;
      end else begin
         upd_vmem = sat;
      end
   end

   assign s2_act        = s2_vld_q && (state_q == SWEEP || state_q == DRAIN);
   assign spike         = s2_act && fire;
   assign stall         = spike && !i_spike_ready;
   assign o_spike_valid = spike;
   assign o_spike_addr  = s2_addr_q;
   assign o_busy        = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      s2_vld_d  = s2_vld_q;
      s2_addr_d = s2_addr_q;
      cfg_load  = 1'b0;
      o_rd_addr = cnt_q;
      o_wr_en   = 1'b0;
      o_wr_addr = s2_addr_q;
      o_vmem_wr = upd_vmem;
      o_ref_wr  = upd_ref;
      o_done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_init_start) begin
               state_d  = INIT;
               cnt_d    = '0;
               cfg_load = 1'b1;
            end else if (i_step_start) begin
               state_d  = SWEEP;
               cnt_d    = '0;
               s2_vld_d = 1'b0;
               cfg_load = 1'b1;
            end
         end
         INIT: begin
            o_wr_en   = 1'b1;
            o_wr_addr = cnt_q;
            o_vmem_wr = vreset_q;
            o_ref_wr  = '0;
            // DRAIN with no S2 pending just emits the done pulse
            if (cnt_q == LAST) begin
               state_d  = DRAIN;
               s2_vld_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SWEEP: begin
            if (stall) begin
               o_rd_addr = s2_addr_q;
            end else begin
               o_wr_en   = s2_vld_q;
               s2_vld_d  = 1'b1;
               s2_addr_d = cnt_q;
               if (cnt_q == LAST)
                  state_d = DRAIN;
               else
                  cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (stall) begin
               o_rd_addr = s2_addr_q;
            end else begin
               o_wr_en   = s2_vld_q;
               o_done    = 1'b1;
               state_d   = IDLE;
               cnt_d     = '0;
               s2_vld_d  = 1'b0;
               s2_addr_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         s2_vld_q  <= 1'b0;
         s2_addr_q <= '0;
         vth_q     <= '0;
         vreset_q  <= '0;
         shift_q   <= '0;
         refp_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s2_vld_q  <= s2_vld_d;
         s2_addr_q <= s2_addr_d;
         if (cfg_load) begin
            vth_q    <= i_cfg_vth;
            vreset_q <= i_cfg_vreset;
            shift_q  <= i_cfg_leak_shift;
            refp_q   <= i_cfg_ref_period;
         end
      end
   end

endmodule

// File: tb/tb_neuron_tdm_controller.sv
// Directed bench for neuron_tdm_controller with a 16-entry LUTRAM and current buffer.
module tb_neuron_tdm_controller;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_step_start = 1'b0, i_init_start = 1'b0;
   logic [15:0] i_cfg_vth = '0, i_cfg_vreset = '0;
   logic [3:0]  i_cfg_leak_shift = '0, i_cfg_ref_period = '0;
   logic [3:0]  o_rd_addr, o_wr_addr, o_spike_addr;
   logic [15:0] i_vmem_rd, i_cur_rd, o_vmem_wr;
   logic [3:0]  i_ref_rd, o_ref_wr;
   logic        o_wr_en, o_spike_valid, o_busy, o_done;
   logic        i_spike_ready = 1'b1;

   logic [15:0] mv [N];
   logic [3:0]  mr [N];
   logic [15:0] mc [N];
   logic        ld_en = 1'b0;
   logic [3:0]  ld_addr = '0, ld_r = '0;
   logic [15:0] ld_v = '0;
   int wcount = 0, scount = 0, last_spk = -1;
   int checks = 0, errors = 0;

   neuron_tdm_controller #(.NUM_NEURONS(N), .VMEM_WIDTH(16), .REF_CTR_WIDTH(4), .CUR_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .i_step_start(i_step_start), .i_init_start(i_init_start),
      .i_cfg_vth(i_cfg_vth), .i_cfg_vreset(i_cfg_vreset), .i_cfg_leak_shift(i_cfg_leak_shift),
      .i_cfg_ref_period(i_cfg_ref_period), .o_rd_addr(o_rd_addr), .i_vmem_rd(i_vmem_rd),
      .i_ref_rd(i_ref_rd), .i_cur_rd(i_cur_rd), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_vmem_wr(o_vmem_wr), .o_ref_wr(o_ref_wr), .o_spike_valid(o_spike_valid),
      .o_spike_addr(o_spike_addr), .i_spike_ready(i_spike_ready), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   // LUTRAM: registered read, synchronous write; bench preload port has priority
   always @(posedge clk) begin
      if (ld_en) begin
         mv[ld_addr] <= ld_v;
         mr[ld_addr] <= ld_r;
      end else if (o_wr_en) begin
         mv[o_wr_addr] <= o_vmem_wr;
         mr[o_wr_addr] <= o_ref_wr;
      end
      i_vmem_rd <= mv[o_rd_addr];
      i_ref_rd  <= mr[o_rd_addr];
      i_cur_rd  <= mc[o_rd_addr];
      if (o_wr_en) wcount <= wcount + 1;
      if (o_spike_valid && i_spike_ready) begin
         scount   <= scount + 1;
         last_spk <= int'(o_spike_addr);
      end
   end

   task automatic load(input int a, input logic [15:0] v, input logic [3:0] r, input logic [15:0] c);
      ld_en = 1'b1; ld_addr = 4'(a); ld_v = v; ld_r = r; mc[a] = c;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic load_all(input logic [15:0] v, input logic [3:0] r, input logic [15:0] c);
      for (int i = 0; i < N; i++) load(i, v, r, c);
   endtask

   task automatic set_cfg(input logic [15:0] vth, input logic [15:0] vrst, input logic [3:0] sh, input logic [3:0] rp);
      i_cfg_vth = vth; i_cfg_vreset = vrst; i_cfg_leak_shift = sh; i_cfg_ref_period = rp;
   endtask

   task automatic pulse(input bit init);
      @(posedge clk); #1;
      if (init) i_init_start = 1'b1; else i_step_start = 1'b1;
      @(posedge clk); #1;
      i_init_start = 1'b0; i_step_start = 1'b0;
   endtask

   // returns the cycle index (1 = first cycle after acceptance) of o_done, bounded
   task automatic run_sweep(output int cyc);
      pulse(1'b0);
      cyc = 0;
      do begin
         @(negedge clk); cyc++;
      end while (!o_done && cyc < 200);
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_wr_en, o_spike_valid, o_busy, o_done} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {o_wr_en, o_spike_valid, o_busy, o_done});
      end
      checks++;
      if ({o_rd_addr, o_wr_addr, o_spike_addr} !== 12'h000) begin
         errors++; $display("FAIL reset_addrs: got %h expected 000", {o_rd_addr, o_wr_addr, o_spike_addr});
      end
      rst = 1'b0;
   endtask

   task automatic test_init;
      int bad = 0;
      set_cfg(16'd200, 16'hFFFB, 4'd0, 4'd0);
      pulse(1'b1);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         if (!(o_wr_en === 1'b1 && o_wr_addr === 4'(k) && o_vmem_wr === 16'hFFFB && o_ref_wr === 4'd0
               && o_spike_valid === 1'b0 && o_busy === 1'b1 && o_done === 1'b0)) begin
            bad++;
            $display("FAIL init_write k=%0d: wr_en=%b addr=%0d vmem=%h ref=%0d expected 1,%0d,fffb,0", k, o_wr_en, o_wr_addr, o_vmem_wr, o_ref_wr, k);
         end
      end
      checks++;
      if (bad != 0) errors++;
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1 || o_wr_en !== 1'b0) begin
         errors++; $display("FAIL init_done: done=%b wr_en=%b expected 1,0", o_done, o_wr_en);
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || mv[7] !== 16'hFFFB || mr[7] !== 4'd0) begin
         errors++; $display("FAIL init_idle: done=%b busy=%b mv7=%h mr7=%0d expected 0,0,fffb,0", o_done, o_busy, mv[7], mr[7]);
      end
   endtask

   task automatic test_priority;
      int cyc = 0;
      set_cfg(16'd200, 16'd9, 4'd0, 4'd0);
      @(posedge clk); #1;
      i_init_start = 1'b1; i_step_start = 1'b1;
      @(posedge clk); #1;
      i_init_start = 1'b0; i_step_start = 1'b0;
      @(negedge clk);
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== 4'd0 || o_vmem_wr !== 16'd9) begin
         errors++; $display("FAIL priority: wr_en=%b addr=%0d vmem=%0d expected 1,0,9", o_wr_en, o_wr_addr, o_vmem_wr);
      end
      while (!o_done && cyc < 100) begin @(negedge clk); cyc++; end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep_leak;
      int cyc, w0, s0, bad = 0;
      load_all(16'd100, 4'd0, 16'd20);
      set_cfg(16'd200, 16'd0, 4'd2, 4'd3);
      w0 = wcount; s0 = scount;
      run_sweep(cyc);
      checks++;
      if (cyc != N + 1) begin errors++; $display("FAIL sweep_latency: got %0d expected %0d", cyc, N + 1); end
      checks++;
      if (wcount - w0 != N || scount != s0) begin
         errors++; $display("FAIL sweep_counts: writes=%0d spikes=%0d expected %0d,0", wcount - w0, scount - s0, N);
      end
      for (int i = 0; i < N; i++) if (mv[i] !== 16'd95 || mr[i] !== 4'd0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL sweep_leak_data: %0d entries wrong, mv0=%0d expected 95", bad, mv[0]); end
   endtask

   task automatic test_spike_refractory;
      int cyc, s0;
      load_all(16'd0, 4'd0, 16'd0);
      load(3, 16'd190, 4'd0, 16'd50);
      set_cfg(16'd200, 16'd0, 4'd0, 4'd3);
      s0 = scount;
      run_sweep(cyc);
      checks++;
      if (scount - s0 != 1 || last_spk != 3) begin
         errors++; $display("FAIL spike_event: spikes=%0d addr=%0d expected 1,3", scount - s0, last_spk);
      end
      checks++;
      if (mv[3] !== 16'd0 || mr[3] !== 4'd3 || mv[4] !== 16'd0) begin
         errors++; $display("FAIL spike_write: mv3=%0d mr3=%0d mv4=%0d expected 0,3,0", mv[3], mr[3], mv[4]);
      end
      s0 = scount;
      run_sweep(cyc);
      checks++;
      if (scount != s0 || mr[3] !== 4'd2 || mv[3] !== 16'd0 || cyc != N + 1) begin
         errors++; $display("FAIL refractory: spikes=%0d mr3=%0d mv3=%0d cyc=%0d expected 0,2,0,%0d", scount - s0, mr[3], mv[3], cyc, N + 1);
      end
   endtask

   task automatic test_stall;
      int cyc = 0, w0, s0;
      load_all(16'd0, 4'd0, 16'd0);
      load(5, 16'd250, 4'd0, 16'd0);
      set_cfg(16'd200, 16'd0, 4'd0, 4'd3);
      i_spike_ready = 1'b0;
      w0 = wcount; s0 = scount;
      pulse(1'b0);
      do begin @(negedge clk); cyc++; end while (o_spike_valid !== 1'b1 && cyc < 50);
      checks++;
      if (cyc != 7) begin errors++; $display("FAIL stall_spike_cycle: got %0d expected 7", cyc); end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (o_spike_valid !== 1'b1 || o_spike_addr !== 4'd5 || o_wr_en !== 1'b0 || o_rd_addr !== 4'd5) begin
            errors++; $display("FAIL stall_hold k=%0d: valid=%b saddr=%0d wr_en=%b rd=%0d expected 1,5,0,5", k, o_spike_valid, o_spike_addr, o_wr_en, o_rd_addr);
         end
      end
      @(posedge clk); #1;
      i_spike_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (o_spike_valid !== 1'b1 || o_wr_en !== 1'b1 || o_wr_addr !== 4'd5 || o_vmem_wr !== 16'd0 || o_ref_wr !== 4'd3 || o_rd_addr !== 4'd6) begin
         errors++; $display("FAIL stall_accept: valid=%b wr_en=%b wa=%0d vmem=%0d ref=%0d rd=%0d expected 1,1,5,0,3,6", o_spike_valid, o_wr_en, o_wr_addr, o_vmem_wr, o_ref_wr, o_rd_addr);
      end
      @(negedge clk);
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== 4'd6 || o_spike_valid !== 1'b0) begin
         errors++; $display("FAIL stall_next: wr_en=%b wa=%0d valid=%b expected 1,6,0", o_wr_en, o_wr_addr, o_spike_valid);
      end
      cyc = 0;
      while (!o_done && cyc < 100) begin @(negedge clk); cyc++; end
      @(posedge clk); #1;
      checks++;
      if (wcount - w0 != N || scount - s0 != 1 || mr[5] !== 4'd3 || mv[5] !== 16'd0) begin
         errors++; $display("FAIL stall_totals: writes=%0d spikes=%0d mr5=%0d mv5=%0d expected %0d,1,3,0", wcount - w0, scount - s0, mr[5], mv[5], N);
      end
   endtask

   task automatic test_saturation;
      int cyc, s0;
      load_all(16'hFC18, 4'd0, 16'd0);
      load(0, 16'h7FF8, 4'd0, 16'd100);
      load(1, 16'h8008, 4'd0, 16'hFF9C);
      set_cfg(16'h7FFF, 16'd7, 4'd0, 4'd2);
      s0 = scount;
      run_sweep(cyc);
      checks++;
      if (scount - s0 != 1 || last_spk != 0 || mv[0] !== 16'd7 || mr[0] !== 4'd2) begin
         errors++; $display("FAIL sat_pos: spikes=%0d addr=%0d mv0=%h mr0=%0d expected 1,0,0007,2", scount - s0, last_spk, mv[0], mr[0]);
      end
      checks++;
      if (mv[1] !== 16'h8000 || mr[1] !== 4'd0 || mv[2] !== 16'hFC18) begin
         errors++; $display("FAIL sat_neg_a: mv1=%h mr1=%0d mv2=%h expected 8000,0,fc18", mv[1], mr[1], mv[2]);
      end
      load(1, 16'h8008, 4'd0, 16'hFF9C);
      set_cfg(16'd0, 16'd7, 4'd0, 4'd2);
      s0 = scount;
      run_sweep(cyc);
      checks++;
      if (scount != s0 || mv[1] !== 16'h8000 || mr[0] !== 4'd1) begin
         errors++; $display("FAIL sat_neg_b: spikes=%0d mv1=%h mr0=%0d expected 0,8000,1", scount - s0, mv[1], mr[0]);
      end
   endtask

   task automatic test_busy_ignore;
      int cyc = 0, extra = 0;
      load_all(16'd0, 4'd0, 16'd0);
      set_cfg(16'd200, 16'd0, 4'd0, 4'd0);
      pulse(1'b0);
      do begin
         @(negedge clk); cyc++;
         if (cyc == 4) begin
            checks++;
            if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b expected 1", o_busy); end
            i_step_start = 1'b1;
         end
         if (cyc == 5) i_step_start = 1'b0;
      end while (!o_done && cyc < 200);
      checks++;
      if (cyc != N + 1) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected %0d", cyc, N + 1); end
      repeat (2 * N) begin
         @(negedge clk);
         if (o_busy || o_done || o_wr_en) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL busy_ignore_restart: %0d active cycles expected 0", extra); end
   endtask

   task automatic test_reset_mid;
      int cyc = 0, w0, act = 0;
      load_all(16'd0, 4'd0, 16'd0);
      set_cfg(16'd200, 16'd0, 4'd0, 4'd0);
      w0 = wcount;
      pulse(1'b0);
      do begin @(negedge clk); cyc++; end while (!(o_wr_en === 1'b1 && o_wr_addr === 4'd10) && cyc < 50);
      checks++;
      if (cyc != 12) begin errors++; $display("FAIL rst_mid_reach: got cycle %0d expected 12", cyc); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (o_wr_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++; $display("FAIL rst_mid_abort: wr_en=%b busy=%b done=%b expected 0,0,0", o_wr_en, o_busy, o_done);
      end
      repeat (2 * N) begin
         @(negedge clk);
         if (o_busy || o_done || o_wr_en) act++;
      end
      checks++;
      if (act != 0 || wcount - w0 != 11) begin
         errors++; $display("FAIL rst_mid_quiet: active=%0d writes=%0d expected 0,11", act, wcount - w0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init();
      test_priority();
      test_sweep_leak();
      test_spike_refractory();
      test_stall();
      test_saturation();
      test_busy_ignore();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
